decoder_rr_arbiter: RTL
=======================

Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares a single 2-to-4 decoder between four requesters.
- Owns the decoder's select (in) and enable (en) inputs; the decoder's one-hot out is the grant vector.
- Adds a grant hold limit, a one-cycle turnaround gap between grants, and a preemption pulse.
- Sits between four request sources and one shared resource selected by one-hot grant.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles one grant stays asserted; legal range 1..15.
- CNT_W, 4: hold counter width; must satisfy 2**CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  level request per requester; bit i belongs to requester i.
- gnt  output  4  one-hot grant, taken directly from the decoder out; all zero when no grant.
- gnt_vld  output  1  high while any grant is active; equals the decoder en.
- gnt_id  output  2  index of the current or most recent grantee; equals the decoder in.
- preempt  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Behaviour:
- Reset (async assert, sync-safe deassert by design):
  - state=IDLE, gnt=0, gnt_vld=0, gnt_id=0, preempt=0, hold_cnt=0.
  - Last-grantee pointer ptr=3, so requester 0 has top priority after reset.
- States: IDLE, BUSY, GAP.
- Arbitration (IDLE and GAP only):
  - Search req starting at (ptr+1) mod 4 and wrapping.
  - The first set bit wins and is loaded into gnt_id and ptr.
  - hold_cnt is set to 1; next state is BUSY.
- Latency: req sampled high at edge n gives gnt high after edge n. One cycle from IDLE, one cycle after the GAP cycle otherwise.
- IDLE: no req leaves the block in IDLE; any req triggers arbitration.
- BUSY:
  - gnt_vld=1, so gnt = 1 << gnt_id.
  - If req[gnt_id] is sampled low, go to GAP; normal release, preempt stays 0.
  - Else if hold_cnt == HOLD_MAX, go to GAP and pulse preempt=1 for the first GAP cycle.
  - Else increment hold_cnt and stay in BUSY.
  - Requests from other requesters never shorten an active grant.
- GAP:
  - gnt_vld=0, gnt=0; gnt_id keeps its value.
  - Arbitrate if any req is set, otherwise go to IDLE.
- Fairness: a preempted requester that is still requesting has lowest priority at the next arbitration. If it is the only requester, it is re-granted after exactly one GAP cycle.
- Grant-duration bound: a grant lasts at most HOLD_MAX cycles. Back-to-back grants are always separated by at least one zero-gnt cycle.
- HOLD_MAX=1: every grant lasts one cycle. If req is still high, preempt pulses after every grant.
- Wrap-around: pointer arithmetic is mod 4; ptr=3 wraps the search to start at 0.
- Simultaneous events: in GAP, a release and a new request are resolved in the same cycle. A request that rises during GAP is eligible in that GAP cycle.
- Reset mid-grant: gnt falls immediately (async), no preempt pulse, and priority returns to requester 0.
- Outputs are registered or derived combinationally only from registered state through the decoder; there is no combinational path from req to gnt.

Decomposition:
- Shared package:
  - State encoding constants: ST_IDLE=2'd0, ST_BUSY=2'd1, ST_GAP=2'd2.
  - N_REQ=4 and ID_W=2; these are fixed by the decoder width.
- Sub-module: instantiate the existing decoder, connecting in<-gnt_id, en<-gnt_vld, out->gnt.
- The round-robin priority search is a local function, not a separate module.

Test Plan:
- Reset then req=4'b0001 held: gnt=0001 from the edge after the req sample, for 8 cycles. Then preempt=1 with gnt=0 for one cycle, then gnt=0001 again.
- req=4'b1111 with each requester dropping after 2 grant cycles: grant order 0,1,2,3,0, each grant 2 cycles with one zero cycle between grants, preempt never set.
- Requester 2 granted while req=4'b0110 and HOLD_MAX expires: preempt pulses, next grant goes to requester 1. Checks that ptr=2 makes the search order 3,0,1.
- req=4'b1000 granted, then req changes to 4'b0001 on the release cycle: one GAP cycle, then gnt=0001 with gnt_id=0.
- Assert rst_n low mid-BUSY (gnt=0100): gnt=0 and gnt_vld=0 immediately. After release with req=4'b0101, the first grant is 0001.
- Checker throughout: gnt is always one-hot or zero, gnt==decoder(gnt_id,gnt_vld), no grant exceeds HOLD_MAX cycles, and preempt is never high in consecutive cycles.

Source files
------------

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared constants for the round-robin arbiter built around a 2-to-4 decoder.
package decoder_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/decoder_rr_arbiter_dec.sv
// 2-to-4 one-hot decoder with enable; drives the shared resource's grant lines.
module decoder_rr_arbiter_dec
    import decoder_rr_arbiter_pkg::*;
(
    input  logic [ID_W-1:0]  in,
    input  logic             en,
    output logic [N_REQ-1:0] out
);

    always_comb begin
        out = '0;
        if (en) out[in] = 1'b1;
    end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter over four requesters with hold limit, turnaround gap and
// preempt pulse; the grant vector comes straight from the shared decoder.
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_vld,
    output logic [ID_W-1:0]  gnt_id,
    output logic             preempt
);

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [CNT_W-1:0] hold_cnt;
    logic [ID_W-1:0]  pick_id;
    logic             arb_req;

    // Search starts just after the last grantee, so it always ends up last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] idx;
        logic            found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = p + ID_W'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign pick_id = rr_pick(req, ptr);
    assign arb_req = |req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= ID_W'(N_REQ - 1);
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                ST_IDLE, ST_GAP: begin
                    if (arb_req) begin
                        gnt_id   <= pick_id;
                        ptr      <= pick_id;
                        hold_cnt <= CNT_W'(1);
                        gnt_vld  <= 1'b1;
                        state    <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!req[gnt_id]) begin
                        gnt_vld <= 1'b0;
                        state   <= ST_GAP;
                    end else if (hold_cnt == CNT_W'(HOLD_MAX)) begin
                        gnt_vld <= 1'b0;
                        preempt <= 1'b1;
                        state   <= ST_GAP;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    gnt_vld <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    decoder_rr_arbiter_dec u_dec (
        .in  (gnt_id),
        .en  (gnt_vld),
        .out (gnt)
    );

endmodule
